// File: rtl/mipi_csi2_pkg.sv
// Shared CSI-2 constants, header field offsets and packet-controller state encoding.
package mipi_csi2_pkg;

  localparam logic [5:0] DT_FS          = 6'h00;
  localparam logic [5:0] DT_FE          = 6'h01;
  localparam logic [5:0] DT_LS          = 6'h02;
  localparam logic [5:0] DT_LE          = 6'h03;
  localparam logic [5:0] DT_RAW10       = 6'h2B;
  localparam logic [5:0] DT_SHORT_LIMIT = 6'h10;

  // Bit offsets inside a 32-bit header beat (byte0 is first on the wire).
  localparam int DT_LSB  = 0;
  localparam int VC_LSB  = 6;
  localparam int WC_LSB  = 8;
  localparam int ECC_LSB = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } pkt_state_e;

endpackage

// File: rtl/mipi_csi2_hdr_decode.sv
// Combinational split of a CSI-2 packet header into VC, DT, WC and simple class checks.
module mipi_csi2_hdr_decode
  import mipi_csi2_pkg::*;
(
  input  logic [23:0] hdr,
  output logic [1:0]  vc,
  output logic [5:0]  dt,
  output logic [15:0] wc,
  output logic        is_short,
  output logic        wc_ok
);

  assign vc       = hdr[VC_LSB +: 2];
  assign dt       = hdr[DT_LSB +: 6];
  assign wc       = hdr[WC_LSB +: 16];
  assign is_short = (dt < DT_SHORT_LIMIT);
  // A RAW10 line packs 4 pixels into 5 bytes, so only non-zero multiples of 5 are legal.
  assign wc_ok    = (wc != 16'd0) && ((wc % 16'd5) == 16'd0);

endmodule

// File: rtl/mipi_csi2_pkt_ctrl.sv
// CSI-2 packet controller: decodes headers, tracks frame/line state and gates RAW10 payload to the unpacker.
module mipi_csi2_pkt_ctrl #(
  parameter logic [1:0] VC_DEFAULT = 2'd0,
  parameter logic [5:0] DT_RAW10   = 6'h2B
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      enable_i,
  input  logic [1:0]                vc_sel_i,
  input  logic                      clear_err_i,
  input  logic [31:0]               data_i,
  input  logic                      data_valid_i,
  input  logic                      sop_i,
  output logic [31:0]               unpack_data_o,
  output logic                      unpack_valid_o,
  output logic                      line_last_o,
  output logic                      frame_start_o,
  output logic                      frame_end_o,
  output logic                      frame_active_o,
  output logic [15:0]               line_count_o,
  output logic [15:0]               frame_count_o,
  output logic                      err_wc_o,
  output logic                      err_trunc_o,
  output logic                      err_seq_o,
  output mipi_csi2_pkg::pkt_state_e state_o
);
  import mipi_csi2_pkg::*;

  // Unpacker handshake: unpack_valid_o qualifies unpack_data_o for one cycle, there is
  // no backpressure, and unpack_data_o is forced to 0 whenever unpack_valid_o is low.

  pkt_state_e  state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [1:0]  vc_sel_q;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d, last_q, last_d, fs_q, fs_d, fe_q, fe_d;
  logic        active_q, active_d;
  logic [15:0] lc_q, lc_d, fc_q, fc_d;
  logic        ewc_q, ewc_d, etr_q, etr_d, esq_q, esq_d;
  logic        decode_hdr;

  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        hdr_short, hdr_wc_ok;

  mipi_csi2_hdr_decode u_hdr_decode (
    .hdr      (data_i[23:0]),
    .vc       (hdr_vc),
    .dt       (hdr_dt),
    .wc       (hdr_wc),
    .is_short (hdr_short),
    .wc_ok    (hdr_wc_ok)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    data_d     = 32'd0;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    fs_d       = 1'b0;
    fe_d       = 1'b0;
    active_d   = active_q;
    lc_d       = lc_q;
    fc_d       = fc_q;
    ewc_d      = clear_err_i ? 1'b0 : ewc_q;
    etr_d      = clear_err_i ? 1'b0 : etr_q;
    esq_d      = clear_err_i ? 1'b0 : esq_q;
    decode_hdr = 1'b0;

    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DROP: begin
          if (data_valid_i && sop_i) decode_hdr = 1'b1;
        end
        ST_PAYLOAD: begin
          if (data_valid_i && sop_i) begin
            etr_d      = 1'b1;
            decode_hdr = 1'b1;
          end else if (!data_valid_i) begin
            // A gap would desynchronise the unpacker, so the rest of the line is discarded.
            etr_d   = 1'b1;
            state_d = ST_DROP;
          end else begin
            valid_d = 1'b1;
            data_d  = data_i;
            rem_d   = (rem_q > 16'd4) ? (rem_q - 16'd4) : 16'd0;
            if (rem_q <= 16'd4) begin
              last_d  = 1'b1;
              lc_d    = lc_q + 16'd1;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (decode_hdr) begin
      state_d = ST_IDLE;
      if (hdr_vc != vc_sel_q) begin
        if (!hdr_short) state_d = ST_DROP;
      end else if (hdr_short) begin
        if (hdr_dt == DT_FS) begin
          fs_d     = 1'b1;
          active_d = 1'b1;
          lc_d     = 16'd0;
          if (active_q) esq_d = 1'b1;
        end else if (hdr_dt == DT_FE) begin
          fe_d     = 1'b1;
          active_d = 1'b0;
          if (active_q) fc_d = fc_q + 16'd1;
          else          esq_d = 1'b1;
        end
      end else if (hdr_dt == DT_RAW10) begin
        if (!hdr_wc_ok) begin
          ewc_d   = 1'b1;
          state_d = ST_DROP;
        end else if (!active_q) begin
          esq_d   = 1'b1;
          state_d = ST_DROP;
        end else begin
          rem_d   = hdr_wc;
          state_d = ST_PAYLOAD;
        end
      end else begin
        state_d = ST_DROP;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      rem_q    <= 16'd0;
      vc_sel_q <= VC_DEFAULT;
      data_q   <= 32'd0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      fs_q     <= 1'b0;
      fe_q     <= 1'b0;
      active_q <= 1'b0;
      lc_q     <= 16'd0;
      fc_q     <= 16'd0;
      ewc_q    <= 1'b0;
      etr_q    <= 1'b0;
      esq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      vc_sel_q <= vc_sel_i;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      fs_q     <= fs_d;
      fe_q     <= fe_d;
      active_q <= active_d;
      lc_q     <= lc_d;
      fc_q     <= fc_d;
      ewc_q    <= ewc_d;
      etr_q    <= etr_d;
      esq_q    <= esq_d;
    end
  end

  assign unpack_data_o  = data_q;
  assign unpack_valid_o = valid_q;
  assign line_last_o    = last_q;
  assign frame_start_o  = fs_q;
  assign frame_end_o    = fe_q;
  assign frame_active_o = active_q;
  assign line_count_o   = lc_q;
  assign frame_count_o  = fc_q;
  assign err_wc_o       = ewc_q;
  assign err_trunc_o    = etr_q;
  assign err_seq_o      = esq_q;
  assign state_o        = state_q;

endmodule
